// File: rtl/segment_to_binary_capture_if.sv
// Segment-line and decoded-result bundle for segment_to_binary_capture.
// SEG_ERR_COUNT_EN adds the saturating invalid-pattern counter to the bundle.
interface segment_to_binary_capture_if;
    logic       i_Segment_A;
    logic       i_Segment_B;
    logic       i_Segment_C;
    logic       i_Segment_D;
    logic       i_Segment_E;
    logic       i_Segment_F;
    logic       i_Segment_G;
    logic [3:0] o_Binary_Num;
    logic       o_Valid;
    logic       o_Invalid;
    logic       o_Stable;
`ifdef SEG_ERR_COUNT_EN
    logic [7:0] o_Error_Count;
`endif

    modport master (
        output i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
               i_Segment_E, i_Segment_F, i_Segment_G,
        input  o_Binary_Num, o_Valid, o_Invalid, o_Stable
`ifdef SEG_ERR_COUNT_EN
        , input o_Error_Count
`endif
    );

    modport slave (
        input  i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
               i_Segment_E, i_Segment_F, i_Segment_G,
        output o_Binary_Num, o_Valid, o_Invalid, o_Stable
`ifdef SEG_ERR_COUNT_EN
        , output o_Error_Count
`endif
    );
endinterface

// File: rtl/segment_to_binary_capture.sv
// Synchronises 7-segment drive lines, waits for a stable pattern, and reports it once
// as a decoded nibble or an invalid flag. Optional: SEG_ERR_COUNT_EN (invalid counter).
//
// state    | meaning
// S_SETTLE | pattern changing or not yet stable for STABLE_CYCLES samples
// S_HELD   | current stable pattern has been reported
module segment_to_binary_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic                         i_Clk,
    input logic                         i_Reset,
    segment_to_binary_capture_if.slave  seg
);

    localparam logic [7:0] COUNT_MAX   = 8'(STABLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic {S_SETTLE, S_HELD} state_t;

    state_t     state;
    logic [6:0] r_Sync1;
    logic [6:0] r_Sync2;
    logic [7:0] count;
    logic [3:0] binary_num;
    logic       valid;
    logic       invalid;
    logic       stable;
    logic [6:0] pattern;
    logic       same;
    logic       legal;
    logic [3:0] decoded;

    assign pattern = {seg.i_Segment_A, seg.i_Segment_B, seg.i_Segment_C, seg.i_Segment_D,
                      seg.i_Segment_E, seg.i_Segment_F, seg.i_Segment_G};
    assign same    = (r_Sync1 == r_Sync2);

    always_comb begin
        legal   = 1'b1;
        decoded = 4'h0;
        case (r_Sync1)
            7'h7E: decoded = 4'h0;
            7'h30: decoded = 4'h1;
            7'h6D: decoded = 4'h2;
            7'h79: decoded = 4'h3;
            7'h33: decoded = 4'h4;
            7'h5B: decoded = 4'h5;
            7'h5F: decoded = 4'h6;
            7'h70: decoded = 4'h7;
            7'h7F: decoded = 4'h8;
            7'h7B: decoded = 4'h9;
            7'h77: decoded = 4'hA;
            7'h1F: decoded = 4'hB;
            7'h4E: decoded = 4'hC;
            7'h3D: decoded = 4'hD;
            7'h4F: decoded = 4'hE;
            7'h47: decoded = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Sync1    <= 7'h00;
            r_Sync2    <= 7'h00;
            count      <= 8'd0;
            state      <= S_SETTLE;
            binary_num <= 4'h0;
            valid      <= 1'b0;
            invalid    <= 1'b0;
            stable     <= 1'b0;
        end else begin
            r_Sync1 <= pattern;
            r_Sync2 <= r_Sync1;
            valid   <= 1'b0;
            invalid <= 1'b0;

            if (!same)
                count <= 8'd0;
            else if (count != COUNT_MAX)
                count <= count + 8'd1;

            case (state)
                S_SETTLE: begin
                    // Report on the same edge that enters S_HELD; decode from the pre-edge sample.
                    if (same && count == SETTLE_LAST) begin
                        state  <= S_HELD;
                        stable <= 1'b1;
                        if (legal) begin
                            binary_num <= decoded;
                            valid      <= 1'b1;
                        end else begin
                            invalid    <= 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    if (!same) begin
                        state  <= S_SETTLE;
                        stable <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_SETTLE;
                    stable <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG_ERR_COUNT_EN
    logic [7:0] error_count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            error_count <= 8'd0;
        else if (state == S_SETTLE && same && count == SETTLE_LAST && !legal
                 && error_count != 8'hFF)
            error_count <= error_count + 8'd1;
    end

    assign seg.o_Error_Count = error_count;
`endif

    assign seg.o_Binary_Num = binary_num;
    assign seg.o_Valid      = valid;
    assign seg.o_Invalid    = invalid;
    assign seg.o_Stable     = stable;

endmodule

// File: tb/tb_segment_to_binary_capture.sv
// Self-checking bench: directed scenarios plus random pattern runs against a
// run-length reference model of the segment capture block.
module tb_segment_to_binary_capture;

    localparam int S = 4;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [6:0] seg_drv;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 i_Clk = ~i_Clk;

    segment_to_binary_capture_if bus ();

    assign bus.i_Segment_A = seg_drv[6];
    assign bus.i_Segment_B = seg_drv[5];
    assign bus.i_Segment_C = seg_drv[4];
    assign bus.i_Segment_D = seg_drv[3];
    assign bus.i_Segment_E = seg_drv[2];
    assign bus.i_Segment_F = seg_drv[1];
    assign bus.i_Segment_G = seg_drv[0];

    segment_to_binary_capture #(.STABLE_CYCLES(S)) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .seg     (bus.slave)
    );

    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference: two sample delay line, and a run of consecutive equal pairs since
    // reset/last change; the S-th equal pair reports, the stable flag lasts while the run does.
    logic [6:0] m_s1, m_s2;
    int         m_run;
    int         m_num;
    bit         m_val, m_inv, m_stb;
    int         m_err;
    int         sweep_cnt;
    int         sweep_vals [$];

    function automatic int lookup(logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic check_val(string tag, int obs, int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int idx;
        if (i_Reset) begin
            m_s1 = 7'h00; m_s2 = 7'h00; m_run = 0;
            m_num = 0; m_val = 0; m_inv = 0; m_stb = 0; m_err = 0;
        end else begin
            m_val = 0;
            m_inv = 0;
            if (m_s1 == m_s2) begin
                if (m_run <= S) m_run++;
                if (m_run == S) begin
                    idx = lookup(m_s1);
                    if (idx >= 0) begin
                        m_num = idx;
                        m_val = 1;
                    end else begin
                        m_inv = 1;
                        if (m_err < 255) m_err++;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_stb = (m_run >= S);
            m_s2  = m_s1;
            m_s1  = seg_drv;
        end
    endtask

    task automatic cyc(logic [6:0] p, bit r = 1'b0);
        seg_drv = p;
        i_Reset = r;
        @(posedge i_Clk);
        model_step();
        #1;
        check_val("valid",   int'(bus.o_Valid),      int'(m_val));
        check_val("invalid", int'(bus.o_Invalid),    int'(m_inv));
        check_val("stable",  int'(bus.o_Stable),     int'(m_stb));
        check_val("num",     int'(bus.o_Binary_Num), m_num);
`ifdef SEG_ERR_COUNT_EN
        check_val("err_cnt", int'(bus.o_Error_Count), m_err);
`endif
        if (bus.o_Valid) begin
            sweep_cnt++;
            sweep_vals.push_back(int'(bus.o_Binary_Num));
        end
    endtask

    task automatic hold(logic [6:0] p, int n);
        for (int i = 0; i < n; i++) cyc(p);
    endtask

    initial begin
        seg_drv = 7'h00;
        i_Reset = 1'b1;
        m_s1 = 0; m_s2 = 0; m_run = 0; m_num = 0;
        m_val = 0; m_inv = 0; m_stb = 0; m_err = 0;
        sweep_cnt = 0;

        for (int i = 0; i < 3; i++) cyc(7'h00, 1'b1);
        hold(7'h00, 8);                      // all-low reports invalid once
        hold(7'h30, 10);                     // value 1

        sweep_cnt = 0;
        sweep_vals.delete();
        for (int i = 0; i < 16; i++) hold(tbl[i], 8);
        check_val("sweep_count", sweep_cnt, 16);
        for (int i = 0; i < 16 && i < sweep_vals.size(); i++)
            check_val("sweep_value", sweep_vals[i], i);

        hold(7'h7E, 10);                     // glitch to 1 and back
        hold(7'h30, 2);
        hold(7'h7E, 10);

        hold(7'h79, 10);                     // illegal after a reported 3
        hold(7'h01, 10);

        hold(7'h00, 8);                      // reset mid-count
        hold(7'h79, 3);
        cyc(7'h79, 1'b1);
        cyc(7'h79, 1'b1);
        hold(7'h79, 10);

        for (int n = 0; n < 250; n++) begin
            logic [6:0] p;
            if ($urandom_range(0, 3) == 0) p = 7'($urandom);
            else                           p = tbl[$urandom_range(0, 15)];
            if ($urandom_range(0, 29) == 0) cyc(p, 1'b1);
            hold(p, int'($urandom_range(1, 10)));
        end

`ifdef SEG_ERR_COUNT_EN
        for (int n = 0; n < 150; n++) begin
            hold(7'h01, 8);
            hold(7'h02, 8);
        end
        check_val("err_sat", int'(bus.o_Error_Count), 255);
        cyc(7'h02, 1'b1);
        check_val("err_reset", int'(bus.o_Error_Count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
